// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encodings, widths,
// default parameters, colour constants and text_on bit positions.
package pong_pkg;

    localparam int unsigned BALL_W  = 2;
    localparam int unsigned TIMER_W = 7;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned TXT_W   = 4;

    localparam int unsigned BALLS_INIT_DEFAULT   = 3;
    localparam int unsigned TIMER_FRAMES_DEFAULT = 120;

    localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;

    // Bit positions inside text_on = {score_on, logo_on, rule_on, over_on}
    localparam int unsigned TXT_SCORE = 3;
    localparam int unsigned TXT_LOGO  = 2;
    localparam int unsigned TXT_RULE  = 1;
    localparam int unsigned TXT_OVER  = 0;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings.
// Inputs : refr_tick, btn, hit, miss, video_on, text_on, text_rgb, graph_on, graph_rgb
// Outputs: dig1, dig0, ball, graph_still, game_state, rgb
// slave  = the controller side, master = the environment driving it.
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic               refr_tick;
    logic [1:0]         btn;
    logic               hit;
    logic               miss;
    logic               video_on;
    logic [TXT_W-1:0]   text_on;
    logic [RGB_W-1:0]   text_rgb;
    logic               graph_on;
    logic [RGB_W-1:0]   graph_rgb;

    logic [DIG_W-1:0]   dig1;
    logic [DIG_W-1:0]   dig0;
    logic [BALL_W-1:0]  ball;
    logic               graph_still;
    logic [1:0]         game_state;
    logic [RGB_W-1:0]   rgb;

    modport master (
        output refr_tick, btn, hit, miss, video_on, text_on, text_rgb, graph_on, graph_rgb,
        input  dig1, dig0, ball, graph_still, game_state, rgb
    );

    modport slave (
        input  refr_tick, btn, hit, miss, video_on, text_on, text_rgb, graph_on, graph_rgb,
        output dig1, dig0, ball, graph_still, game_state, rgb
    );

endinterface

// File: rtl/pong_score_bcd.sv
// Two-digit saturating BCD score counter (00..99).
// Ports: clk, reset (sync, active-high), clr (clear, beats inc),
//        inc (add one), dig1/dig0 (tens/ones BCD digits, registered).
module pong_score_bcd
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [DIG_W-1:0] dig1,
    output logic [DIG_W-1:0] dig0
);

    logic at_max;

    assign at_max = (dig1 == 4'd9) && (dig0 == 4'd9);

    // Ones wrap 9->0 with carry; the whole counter stops at 99
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            dig1 <= 4'd0;
            dig0 <= 4'd0;
        end else if (inc && !at_max) begin
            if (dig0 == 4'd9) begin
                dig0 <= 4'd0;
                dig1 <= dig1 + 4'd1;
            end else begin
                dig0 <= dig0 + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Top-level pong game sequencer: game FSM, balls-remaining count, inter-ball
// delay timer, BCD score and the final registered pixel colour mux.
// Ports: clk, reset (sync, active-high), bus (pong_game_ctrl_if.slave) carrying
//        refr_tick/btn/hit/miss/video_on/text_on/text_rgb/graph_on/graph_rgb in
//        and dig1/dig0/ball/graph_still/game_state/rgb out.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALLS_INIT   = BALLS_INIT_DEFAULT,
    parameter int unsigned TIMER_FRAMES = TIMER_FRAMES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    pong_game_ctrl_if.slave    bus
);

    localparam logic [BALL_W-1:0]  BALL_RELOAD = BALL_W'(BALLS_INIT);
    localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(TIMER_FRAMES - 1);

    state_e              state, state_d;
    logic [BALL_W-1:0]   ball, ball_d;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic [RGB_W-1:0]    rgb_q, rgb_d;
    logic                timer_load;
    logic                score_clr;
    logic                score_inc;
    logic                btn_any;

    assign btn_any = (bus.btn != 2'b00);

    // State, ball count, timer and pixel registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_NEWGAME;
            ball  <= BALL_RELOAD;
            timer <= '0;
            rgb_q <= RGB_BLACK;
        end else begin
            state <= state_d;
            ball  <= ball_d;
            timer <= timer_d;
            rgb_q <= rgb_d;
        end
    end

    // Next-state, ball count and score control
    always_comb begin
        state_d    = state;
        ball_d     = ball;
        timer_load = 1'b0;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        case (state)
            ST_NEWGAME: begin
                score_clr = 1'b1;
                ball_d    = BALL_RELOAD;
                if (btn_any) begin
                    state_d = ST_PLAY;
                    ball_d  = ball - 2'd1;
                end
            end
            ST_PLAY: begin
                score_inc = bus.hit;
                if (bus.miss) begin
                    timer_load = 1'b1;
                    state_d    = (ball == '0) ? ST_OVER : ST_NEWBALL;
                end
            end
            ST_NEWBALL: begin
                if ((timer == '0) && btn_any) begin
                    state_d = ST_PLAY;
                    ball_d  = ball - 2'd1;
                end
            end
            ST_OVER: begin
                if (timer == '0) begin
                    state_d   = ST_NEWGAME;
                    score_clr = 1'b1;
                    ball_d    = BALL_RELOAD;
                end
            end
            default: state_d = ST_NEWGAME;
        endcase
    end

    // Delay timer: load beats a same-cycle refr_tick, then counts down to 0 and sticks
    always_comb begin
        timer_d = timer;
        if (timer_load) begin
            timer_d = TIMER_LOAD;
        end else if (bus.refr_tick && (timer != '0)) begin
            timer_d = timer - 7'd1;
        end
    end

    // Pixel priority: blanking, foreground text, graphics, logo background, black
    always_comb begin
        rgb_d = RGB_BLACK;
        if (!bus.video_on) begin
            rgb_d = RGB_BLACK;
        end else if (bus.text_on[TXT_SCORE] ||
                     ((state == ST_NEWGAME) && bus.text_on[TXT_RULE]) ||
                     ((state == ST_OVER) && bus.text_on[TXT_OVER])) begin
            rgb_d = bus.text_rgb;
        end else if (bus.graph_on) begin
            rgb_d = bus.graph_rgb;
        end else if (bus.text_on[TXT_LOGO]) begin
            rgb_d = bus.text_rgb;
        end
    end

    pong_score_bcd u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .dig1  (bus.dig1),
        .dig0  (bus.dig0)
    );

    assign bus.ball        = ball;
    assign bus.graph_still = (state != ST_PLAY);
    assign bus.game_state  = state;
    assign bus.rgb         = rgb_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    localparam logic [11:0] TXT = 12'hABC;
    localparam logic [11:0] GRA = 12'h123;
    localparam logic [11:0] BLK = 12'h000;

    localparam logic [1:0] S_NEWGAME = 2'd0;
    localparam logic [1:0] S_PLAY    = 2'd1;
    localparam logic [1:0] S_NEWBALL = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        video_on;
        logic [3:0]  text_on;
        logic        graph_on;
        logic [11:0] exp_ng;
        logic [11:0] exp_play;
        logic [11:0] exp_over;
    } rgb_vec_t;

    rgb_vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_hit(input int n);
        for (int i = 0; i < n; i++) begin
            bus.hit = 1'b1;
            step(1);
            bus.hit = 1'b0;
        end
    endtask

    task automatic pulse_miss();
        bus.miss = 1'b1;
        step(1);
        bus.miss = 1'b0;
    endtask

    task automatic pulse_btn();
        bus.btn = 2'b01;
        step(1);
        bus.btn = 2'b00;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.refr_tick = 1'b1;
            step(1);
            bus.refr_tick = 1'b0;
            step(1);
        end
    endtask

    // sel: 0 = NEWGAME column, 1 = PLAY column, 2 = OVER column
    task automatic run_table(input string tag, input int sel);
        logic [11:0] exp;
        for (int i = 0; i < 9; i++) begin
            bus.video_on = vecs[i].video_on;
            bus.text_on  = vecs[i].text_on;
            bus.graph_on = vecs[i].graph_on;
            step(1);
            exp = (sel == 0) ? vecs[i].exp_ng : (sel == 1) ? vecs[i].exp_play : vecs[i].exp_over;
            check($sformatf("rgb_%s_%0d", tag, i), int'(bus.rgb), int'(exp));
        end
        bus.video_on = 1'b1;
        bus.text_on  = 4'b0000;
        bus.graph_on = 1'b0;
    endtask

    task automatic check_core(input string tag, input logic [1:0] st,
                              input logic [3:0] d1, input logic [3:0] d0, input logic [1:0] bl);
        check({tag, "_state"}, int'(bus.game_state), int'(st));
        check({tag, "_dig1"},  int'(bus.dig1), int'(d1));
        check({tag, "_dig0"},  int'(bus.dig0), int'(d0));
        check({tag, "_ball"},  int'(bus.ball), int'(bl));
        check({tag, "_still"}, int'(bus.graph_still), int'(st != S_PLAY));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //            video text     graph NEWGAME PLAY OVER
        vecs[0] = '{1'b0, 4'b1111, 1'b1, BLK, BLK, BLK};
        vecs[1] = '{1'b1, 4'b1000, 1'b1, TXT, TXT, TXT};
        vecs[2] = '{1'b1, 4'b0010, 1'b1, TXT, GRA, GRA};
        vecs[3] = '{1'b1, 4'b0001, 1'b1, GRA, GRA, TXT};
        vecs[4] = '{1'b1, 4'b0100, 1'b0, TXT, TXT, TXT};
        vecs[5] = '{1'b1, 4'b0100, 1'b1, GRA, GRA, GRA};
        vecs[6] = '{1'b1, 4'b0000, 1'b0, BLK, BLK, BLK};
        vecs[7] = '{1'b1, 4'b0010, 1'b0, TXT, BLK, BLK};
        vecs[8] = '{1'b1, 4'b0001, 1'b0, BLK, BLK, TXT};

        reset         = 1'b1;
        bus.refr_tick = 1'b0;
        bus.btn       = 2'b00;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        bus.video_on  = 1'b1;
        bus.text_on   = 4'b1111;
        bus.graph_on  = 1'b1;
        bus.text_rgb  = TXT;
        bus.graph_rgb = GRA;
        step(2);
        check_core("reset", S_NEWGAME, 4'd0, 4'd0, 2'd3);
        check("reset_rgb", int'(bus.rgb), int'(BLK));
        reset = 1'b0;
        bus.text_on  = 4'b0000;
        bus.graph_on = 1'b0;
        step(1);

        // Hit/miss outside PLAY do nothing
        pulse_hit(1);
        pulse_miss();
        check_core("idle_ignore", S_NEWGAME, 4'd0, 4'd0, 2'd3);
        run_table("ng", 0);

        // Game 1
        pulse_btn();
        check_core("start", S_PLAY, 4'd0, 4'd0, 2'd2);
        run_table("play", 1);
        pulse_hit(12);
        check_core("hit12", S_PLAY, 4'd1, 4'd2, 2'd2);
        pulse_hit(87);
        check_core("hit99", S_PLAY, 4'd9, 4'd9, 2'd2);
        pulse_hit(3);
        check_core("sat99", S_PLAY, 4'd9, 4'd9, 2'd2);

        pulse_miss();
        check_core("miss_b2", S_NEWBALL, 4'd9, 4'd9, 2'd2);
        bus.btn = 2'b11;
        pulse_hit(1);
        run_ticks(118);
        check_core("nb_wait", S_NEWBALL, 4'd9, 4'd9, 2'd2);
        run_ticks(1);
        check_core("nb_play", S_PLAY, 4'd9, 4'd9, 2'd1);
        bus.btn = 2'b00;

        pulse_miss();
        bus.btn = 2'b01;
        step(3);
        check_core("nb_btn_early", S_NEWBALL, 4'd9, 4'd9, 2'd1);
        bus.btn = 2'b00;
        run_ticks(119);
        pulse_btn();
        check_core("nb_play2", S_PLAY, 4'd9, 4'd9, 2'd0);
        pulse_miss();
        check_core("over", S_OVER, 4'd9, 4'd9, 2'd0);
        run_table("over", 2);
        run_ticks(118);
        check_core("over_wait", S_OVER, 4'd9, 4'd9, 2'd0);
        run_ticks(1);
        check_core("newgame", S_NEWGAME, 4'd0, 4'd0, 2'd3);

        // Game 2: same-cycle hit+miss, with a refr_tick in the load cycle
        pulse_btn();
        pulse_hit(5);
        pulse_miss();
        run_ticks(119);
        pulse_btn();
        check_core("g2_b1", S_PLAY, 4'd0, 4'd5, 2'd1);
        bus.hit       = 1'b1;
        bus.miss      = 1'b1;
        bus.refr_tick = 1'b1;
        step(1);
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        bus.refr_tick = 1'b0;
        check_core("hitmiss", S_NEWBALL, 4'd0, 4'd6, 2'd1);
        bus.btn = 2'b10;
        run_ticks(118);
        check_core("load_wins", S_NEWBALL, 4'd0, 4'd6, 2'd1);
        run_ticks(1);
        check_core("hm_play", S_PLAY, 4'd0, 4'd6, 2'd0);
        bus.btn = 2'b00;

        // Reset mid-game with a pending timer
        pulse_miss();
        check_core("pre_rst", S_OVER, 4'd0, 4'd6, 2'd0);
        bus.text_on  = 4'b0010;
        bus.graph_on = 1'b1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_core("mid_rst", S_NEWGAME, 4'd0, 4'd0, 2'd3);
        check("mid_rst_rgb", int'(bus.rgb), int'(BLK));
        step(1);
        check("post_rst_rgb", int'(bus.rgb), int'(TXT));
        check_core("post_rst", S_NEWGAME, 4'd0, 4'd0, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
